// File: rtl/camera_pattern_tx.sv
// Synthetic camera sensor source: drives D/FVAL/LVAL with deterministic test patterns
// and parameterised active/blanking geometry, all outputs registered on clk.
module camera_pattern_tx #(
    parameter int DATA_W   = 12,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 160,
    parameter int FV_SETUP = 4,
    parameter int V_BLANK  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        pattern_sel,
    output logic [DATA_W-1:0] D,
    output logic              FVAL,
    output logic              LVAL,
    output logic              frame_start,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              busy
);

    localparam int XW   = $clog2(H_ACTIVE + 1);
    localparam int YW   = $clog2(V_ACTIVE + 1);
    localparam int CMAX = (FV_SETUP > H_BLANK) ? ((FV_SETUP > V_BLANK) ? FV_SETUP : V_BLANK)
                                               : ((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [XW-1:0] X_LAST     = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(FV_SETUP - 1);
    localparam logic [CW-1:0] HB_LAST    = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] VB_LAST    = CW'(V_BLANK - 1);

    typedef enum logic [2:0] {IDLE, SETUP, LINE, HBLANK, VBLANK} state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] cnt;
    logic [1:0]    pat;
    logic [15:0]   stamp;

    function automatic logic [DATA_W-1:0] pix(input logic [1:0] sel, input logic [XW-1:0] px,
                                              input logic [YW-1:0] py, input logic [15:0] st);
        logic [31:0] xe;
        logic [31:0] ye;
        xe = 32'(px);
        ye = 32'(py);
        case (sel)
            2'd0:    return DATA_W'(px);
            2'd1:    return DATA_W'(py);
            2'd2:    return (xe[3] ^ ye[3]) ? {DATA_W{1'b1}} : '0;
            default: return DATA_W'(st);
        endcase
    endfunction

    // Outputs are computed for the state being entered, so D is valid on the same cycle as LVAL.
    always_ff @(posedge clk) begin
        // NOTE: pulse defaults use non-blocking assignment; a later branch assignment wins, so no glitches.
        frame_start <= 1'b0;
        frame_done  <= 1'b0;
        if (reset) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            cnt         <= '0;
            pat         <= '0;
            stamp       <= '0;
            D           <= '0;
            FVAL        <= 1'b0;
            LVAL        <= 1'b0;
            frame_count <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state       <= SETUP;
                        FVAL        <= 1'b1;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                        pat         <= pattern_sel;
                        stamp       <= frame_count;
                        y           <= '0;
                        cnt         <= '0;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state <= LINE;
                        x     <= '0;
                        LVAL  <= 1'b1;
                        D     <= pix(pat, '0, y, stamp);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LINE: begin
                    if (x == X_LAST) begin
                        LVAL <= 1'b0;
                        D    <= '0;
                        cnt  <= '0;
                        if (y == Y_LAST) begin
                            // No trailing HBLANK: FVAL drops right after the last pixel.
                            state       <= VBLANK;
                            FVAL        <= 1'b0;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 1'b1;
                        end else begin
                            state <= HBLANK;
                        end
                    end else begin
                        x <= x + 1'b1;
                        D <= pix(pat, x + 1'b1, y, stamp);
                    end
                end
                HBLANK: begin
                    if (cnt == HB_LAST) begin
                        state <= LINE;
                        x     <= '0;
                        y     <= y + 1'b1;
                        LVAL  <= 1'b1;
                        D     <= pix(pat, '0, y + 1'b1, stamp);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                VBLANK: begin
                    if (cnt == VB_LAST) begin
                        if (enable) begin
                            state       <= SETUP;
                            FVAL        <= 1'b1;
                            frame_start <= 1'b1;
                            pat         <= pattern_sel;
                            stamp       <= frame_count;
                            y           <= '0;
                            cnt         <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
